// File: rtl/filter_mac_engine_if.sv
// Bundles the filter_mac_engine's run control, data, weight-RAM and result
// signals; the engine connects through the slave modport.
interface filter_mac_engine_if #(
    parameter int Bit_width          = 8,
    parameter int Depth_counter_bits = 3
);
    // Start is sampled only while Busy is low; Result_valid and Done are
    // one-cycle strobes with no back-pressure.
    logic                          Start;
    logic [Bit_width-1:0]          Data_in_0;
    logic [Bit_width-1:0]          Data_in_1;
    logic [Bit_width-1:0]          Data_in_2;
    logic [Bit_width-1:0]          Data_in_3;
    logic [Bit_width-1:0]          Data_in_4;
    logic [Bit_width-1:0]          Weight_in_0;
    logic [Bit_width-1:0]          Weight_in_1;
    logic [Bit_width-1:0]          Weight_in_2;
    logic [Bit_width-1:0]          Weight_in_3;
    logic [Bit_width-1:0]          Weight_in_4;
    logic [Bit_width-1:0]          Weight_in_5;
    logic                          Read_en;
    logic [Depth_counter_bits-1:0] Address_depth_read;
    logic [Bit_width-1:0]          Result_out;
    logic [Depth_counter_bits-1:0] Result_index;
    logic                          Result_valid;
    logic                          Busy;
    logic                          Done;
    logic [1:0]                    state_dbg;

    modport master (
        output Start, Data_in_0, Data_in_1, Data_in_2, Data_in_3, Data_in_4,
        output Weight_in_0, Weight_in_1, Weight_in_2, Weight_in_3, Weight_in_4, Weight_in_5,
        input  Read_en, Address_depth_read, Result_out, Result_index,
        input  Result_valid, Busy, Done, state_dbg
    );

    modport slave (
        input  Start, Data_in_0, Data_in_1, Data_in_2, Data_in_3, Data_in_4,
        input  Weight_in_0, Weight_in_1, Weight_in_2, Weight_in_3, Weight_in_4, Weight_in_5,
        output Read_en, Address_depth_read, Result_out, Result_index,
        output Result_valid, Busy, Done, state_dbg
    );
endinterface

// File: rtl/filter_mac_engine.sv
// Walks every filter in the weight RAM, forms a 5-tap signed MAC plus bias,
// and emits one ReLU/saturated result per filter.
module filter_mac_engine #(
    parameter int Bit_width          = 8,
    parameter int Nr_depth           = 8,
    parameter int Depth_counter_bits = 3,
    parameter int Frac_bits          = 4,
    parameter int Acc_width          = 20
) (
    input  logic              Clk,
    input  logic              Reset,
    filter_mac_engine_if.slave bus
);

    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, CALC = 2'd2, WRITE = 2'd3} state_t;

    localparam logic [Depth_counter_bits-1:0] LAST_FILTER = Depth_counter_bits'(Nr_depth - 1);
    localparam logic signed [Acc_width-1:0]   SAT_MAX     = Acc_width'((1 << (Bit_width - 1)) - 1);

    state_t                          state;
    logic [Depth_counter_bits-1:0]   d;
    logic signed [Acc_width-1:0]     acc;
    logic signed [Acc_width-1:0]     acc_next;
    logic signed [Acc_width-1:0]     acc_shifted;
    logic [Bit_width-1:0]            result_clamped;

    function automatic logic signed [Acc_width-1:0] sx(input logic [Bit_width-1:0] v);
        return {{(Acc_width - Bit_width){v[Bit_width-1]}}, v};
    endfunction

    // Accumulator width is chosen so this sum can never wrap.
    always_comb begin
        acc_next = sx(bus.Weight_in_5) <<< Frac_bits;
        acc_next = acc_next + sx(bus.Data_in_0) * sx(bus.Weight_in_0);
        acc_next = acc_next + sx(bus.Data_in_1) * sx(bus.Weight_in_1);
        acc_next = acc_next + sx(bus.Data_in_2) * sx(bus.Weight_in_2);
        acc_next = acc_next + sx(bus.Data_in_3) * sx(bus.Weight_in_3);
        acc_next = acc_next + sx(bus.Data_in_4) * sx(bus.Weight_in_4);
    end

    // Drop the fraction, then ReLU and clamp to the largest positive code.
    always_comb begin
        acc_shifted = acc >>> Frac_bits;
        if (acc_shifted[Acc_width-1])
            result_clamped = '0;
        else if (acc_shifted > SAT_MAX)
            result_clamped = SAT_MAX[Bit_width-1:0];
        else
            result_clamped = acc_shifted[Bit_width-1:0];
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state                  <= IDLE;
            d                      <= '0;
            acc                    <= '0;
            bus.Read_en            <= 1'b0;
            bus.Address_depth_read <= '0;
            bus.Result_out         <= '0;
            bus.Result_index       <= '0;
            bus.Result_valid       <= 1'b0;
            bus.Busy               <= 1'b0;
            bus.Done               <= 1'b0;
        end else begin
            bus.Result_valid <= 1'b0;
            bus.Done         <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        state                  <= FETCH;
                        d                      <= '0;
                        bus.Read_en            <= 1'b1;
                        bus.Address_depth_read <= '0;
                        bus.Busy               <= 1'b1;
                    end
                end
                FETCH: begin
                    // RAM latches its outputs mid-cycle; dropping Read_en holds them.
                    state       <= CALC;
                    bus.Read_en <= 1'b0;
                end
                CALC: begin
                    acc   <= acc_next;
                    state <= WRITE;
                end
                WRITE: begin
                    bus.Result_out   <= result_clamped;
                    bus.Result_index <= d;
                    bus.Result_valid <= 1'b1;
                    if (d == LAST_FILTER) begin
                        state    <= IDLE;
                        bus.Busy <= 1'b0;
                        bus.Done <= 1'b1;
                    end else begin
                        d                      <= d + 1'b1;
                        state                  <= FETCH;
                        bus.Read_en            <= 1'b1;
                        bus.Address_depth_read <= d + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.state_dbg = state;

endmodule
